// File: rtl/arb_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
// Also holds the cyclic priority search used by the arbitration step.
package arb_pkg;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GRANT = 2'b01,
      GAP   = 2'b10
   } arb_state_e;

   // First asserted request after 'last', wrapping modulo N_REQ; 'last' itself is checked last.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [IDX_W-1:0] last);
      logic [IDX_W-1:0] cand;
      logic [IDX_W-1:0] pick;
      logic             found;
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = last + IDX_W'(k);
         if (!found && req[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/dec2_4_onehot.sv
// Combinational 2-to-4 one-hot decoder with enable; all-zero when disabled.
module dec2_4_onehot
   import arb_pkg::*;
(
   input  logic [IDX_W-1:0] idx_i,
   input  logic             en_i,
   output logic [N_REQ-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) onehot_o[idx_i] = 1'b1;
   end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with bounded hold time and a turnaround gap.
// All outputs are registered; gnt is the decoded next-state index/valid.
module rr_arbiter4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16,
   parameter int GAP_CYC  = 1
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_vld,
   output logic       timeout
);

   localparam int               HOLD_W    = $clog2(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
   localparam logic [2:0]       GAP_LAST  = 3'(GAP_CYC - 1);

   arb_state_e        state_q, state_d;
   logic [IDX_W-1:0]  last_q, last_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [2:0]        gap_q, gap_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              vld_q, vld_d;
   logic              to_q, to_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic              release_c;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      hold_d    = hold_q;
      gap_d     = gap_q;
      idx_d     = idx_q;
      vld_d     = vld_q;
      to_d      = 1'b0;
      release_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               idx_d   = rr_pick(req, last_q);
               vld_d   = 1'b1;
               hold_d  = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            release_c = done || !req[idx_q] || (hold_q == HOLD_LAST);
            if (release_c) begin
               // Expiry only reports a timeout when neither done nor withdrawal caused the release.
               to_d    = !done && req[idx_q];
               last_d  = idx_q;
               vld_d   = 1'b0;
               gap_d   = '0;
               state_d = GAP;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) state_d = IDLE;
            else                   gap_d   = gap_q + 3'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   dec2_4_onehot u_dec (
      .idx_i    (idx_d),
      .en_i     (vld_d),
      .onehot_o (gnt_d)
   );

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= IDLE;
         last_q  <= 2'd3;
         hold_q  <= '0;
         gap_q   <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         to_q    <= 1'b0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         to_q    <= to_d;
         gnt_q   <= gnt_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_idx = idx_q;
   assign gnt_vld = vld_q;
   assign timeout = to_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed scenarios plus random traffic against a grant-level reference model.
module tb_rr_arbiter4;

   localparam int MAX_HOLD = 16;
   localparam int GAP_CYC  = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_vld;
   logic       timeout;
   logic [7:0] obs;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the resource, how many cycles it has shown valid, cooldown left.
   bit m_busy  = 1'b0;
   int m_owner = 0;
   int m_held  = 0;
   int m_wait  = 0;
   int m_last  = 3;
   bit m_to    = 1'b0;

   rr_arbiter4 #(.MAX_HOLD(MAX_HOLD), .GAP_CYC(GAP_CYC)) dut (
      .sys_clk (clk),
      .sys_rst (rst),
      .req     (req),
      .done    (done),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   assign obs = {gnt, gnt_idx, gnt_vld, timeout};

   function automatic logic [7:0] exp_vec();
      logic [3:0] eg;
      eg = m_busy ? 4'(1 << m_owner) : 4'b0000;
      return {eg, 2'(m_owner), m_busy, m_to};
   endfunction

   task automatic model_step();
      int c;
      if (rst) begin
         m_busy = 0; m_owner = 0; m_held = 0; m_wait = 0; m_last = 3; m_to = 0;
      end else begin
         m_to = 0;
         if (m_busy) begin
            if (done || !req[m_owner] || m_held == MAX_HOLD) begin
               m_to   = !done && req[m_owner];
               m_last = m_owner;
               m_busy = 0;
               m_wait = GAP_CYC;
            end else begin
               m_held++;
            end
         end else if (m_wait > 0) begin
            m_wait--;
         end else if (req != 4'b0000) begin
            for (int k = 4; k >= 1; k--) begin
               c = (m_last + k) % 4;
               if (req[c]) m_owner = c;
            end
            m_busy = 1;
            m_held = 1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 4'b0000; done = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b1111; done = 1'b1;
      tick(); tick();
      checks++;
      if (obs !== 8'b0000_00_0_0) begin
         errors++; $display("FAIL reset_outputs got=%b exp=%b", obs, 8'b0);
      end
      checks++;
      if (obs !== exp_vec()) begin
         errors++; $display("FAIL reset_model got=%b exp=%b", obs, exp_vec());
      end
      rst = 1'b0; req = 4'b0000; done = 1'b0;
   endtask

   task automatic test_rotation();
      logic [3:0] order[$];
      logic [3:0] exp_ord[5];
      logic       prev;
      exp_ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      prev = 1'b0;
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 40; c++) begin
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL rotation cyc=%0d got=%b exp=%b", c, obs, exp_vec());
         end
         if (gnt_vld && !prev) order.push_back(gnt);
         prev = gnt_vld;
         done = m_busy && (m_held == 2);
      end
      done = 1'b0;
      checks++;
      if (order.size() < 5) begin
         errors++; $display("FAIL rotation_count got=%0d exp>=5", order.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (order[i] !== exp_ord[i]) begin
               errors++; $display("FAIL rotation_order i=%0d got=%b exp=%b", i, order[i], exp_ord[i]);
               break;
            end
         end
      end
   endtask

   task automatic test_timeout();
      int  runs[$];
      int  len;
      int  to_cyc;
      len = 0; to_cyc = 0;
      do_reset();
      req = 4'b0100;
      for (int c = 0; c < 45; c++) begin
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL timeout_seq cyc=%0d got=%b exp=%b", c, obs, exp_vec());
         end
         if (gnt_vld) len++;
         else if (len > 0) begin runs.push_back(len); len = 0; end
         if (timeout) to_cyc++;
      end
      checks++;
      if (runs.size() < 1 || runs[0] != MAX_HOLD) begin
         errors++; $display("FAIL timeout_hold_len got=%0d exp=%0d", (runs.size() > 0) ? runs[0] : -1, MAX_HOLD);
      end
      checks++;
      if (to_cyc != 2) begin
         errors++; $display("FAIL timeout_pulses got=%0d exp=2", to_cyc);
      end
   endtask

   task automatic test_hold_ignore();
      logic [3:0] order[$];
      logic       prev;
      do_reset();
      req = 4'b0010;
      tick();
      req = 4'b1011;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if (gnt !== 4'b0010 || obs !== exp_vec()) begin
            errors++; $display("FAIL hold_stable cyc=%0d got=%b exp=%b", c, obs, exp_vec());
         end
      end
      done = 1'b1;
      prev = 1'b1;
      for (int c = 0; c < 14; c++) begin
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL hold_next cyc=%0d got=%b exp=%b", c, obs, exp_vec());
         end
         if (gnt_vld && !prev) order.push_back(gnt);
         prev = gnt_vld;
         done = m_busy && (m_held == 2);
      end
      done = 1'b0;
      checks++;
      if (order.size() < 2 || order[0] !== 4'b1000 || order[1] !== 4'b0001) begin
         errors++;
         $display("FAIL hold_order got=%b,%b exp=1000,0001",
                  (order.size() > 0) ? order[0] : 4'bx, (order.size() > 1) ? order[1] : 4'bx);
      end
   endtask

   task automatic test_withdraw();
      do_reset();
      req = 4'b0100;
      tick(); tick(); tick(); tick();
      req = 4'b0000;
      tick();
      checks++;
      if (gnt !== 4'b0000 || timeout !== 1'b0 || gnt_idx !== 2'd2 || obs !== exp_vec()) begin
         errors++; $display("FAIL withdraw_release got=%b exp=%b", obs, exp_vec());
      end
      req = 4'b1111;
      tick(); tick();
      checks++;
      if (gnt !== 4'b1000 || obs !== exp_vec()) begin
         errors++; $display("FAIL withdraw_next got=%b exp=%b", obs, exp_vec());
      end
   endtask

   task automatic test_done_at_expiry();
      int len;
      int first_len;
      int to_cyc;
      len = 0; first_len = -1; to_cyc = 0;
      do_reset();
      req = 4'b0001;
      for (int c = 0; c < 30; c++) begin
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL expiry_seq cyc=%0d got=%b exp=%b", c, obs, exp_vec());
         end
         if (gnt_vld) len++;
         else if (len > 0 && first_len < 0) first_len = len;
         if (timeout) to_cyc++;
         done = m_busy && (m_held == MAX_HOLD);
      end
      done = 1'b0;
      checks++;
      if (to_cyc != 0 || first_len != MAX_HOLD) begin
         errors++; $display("FAIL expiry_done timeouts=%0d len=%0d exp 0 and %0d", to_cyc, first_len, MAX_HOLD);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 4'b1111;
      tick(); tick(); tick();
      checks++;
      if (gnt_vld !== 1'b1 || gnt !== 4'b0001) begin
         errors++; $display("FAIL midrst_pre got=%b exp=0001 valid", obs);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (obs !== 8'b0000_00_0_0) begin
         errors++; $display("FAIL midrst_clear got=%b exp=%b", obs, 8'b0);
      end
      rst = 1'b0; req = 4'b1010;
      tick();
      checks++;
      if (gnt !== 4'b0010 || gnt_idx !== 2'd1 || obs !== exp_vec()) begin
         errors++; $display("FAIL midrst_first got=%b exp=%b", obs, exp_vec());
      end
   endtask

   task automatic test_random();
      do_reset();
      req = 4'($urandom);
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 9) == 0) req = 4'($urandom);
         done = ($urandom_range(0, 19) == 0);
         rst  = ($urandom_range(0, 299) == 0);
         tick();
         checks++;
         if (obs !== exp_vec() || $countones(gnt) > 1) begin
            errors++; $display("FAIL random cyc=%0d got=%b exp=%b", c, obs, exp_vec());
         end
      end
      rst = 1'b0; done = 1'b0; req = 4'b0000;
   endtask

   initial begin
      rst = 1'b1; req = 4'b0000; done = 1'b0;
      test_reset();
      test_rotation();
      test_timeout();
      test_hold_ignore();
      test_withdraw();
      test_done_at_expiry();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
